pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the multi-cycle CPU. It replaces the plain PC register with several pieces: registered next-PC selection (sequential, branch, jump, register-jump, return), an exception/ERET path with an EPC register, misalignment trapping, and a small circular return-address stack (RAS). It sits between the control FSM (which drives `pc_en` / `pc_sel` / `exc` / `eret`) and the instruction-memory address port.

## Interface
- `WIDTH`, 32, address width in bits.
- `RESET_VEC`, 32'h0000_0000, PC value on reset.
- `EXC_VEC`, 32'h0000_0180, PC value on exception or misalignment trap.
- `INC`, 4, sequential increment.
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc_en` in 1: PC write enable (PCWrite from the control FSM).
- `pc_sel` in 3: next-PC source, encoded as `PC_SEQ`/`PC_BR`/`PC_J`/`PC_JR`/`PC_RET`.
- `br_target` in WIDTH: branch target.
- `j_target` in WIDTH: jump target.
- `jr_target` in WIDTH: register target; also the fallback for `PC_RET` when the RAS is empty.
- `push` in 1: call; pushes `pc_plus` onto the RAS when `pc_en`.
- `exc` in 1: take exception (qualified by `pc_en`).
- `eret` in 1: return from exception (qualified by `pc_en`).
- `pc` out WIDTH: current PC (registered).
- `pc_plus` out WIDTH: `pc + INC` (combinational).
- `epc` out WIDTH: saved exception PC (registered).
- `align_err` out 1: one-cycle pulse on a misalignment trap.
- `ras_empty` out 1: RAS holds 0 entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.
- `ras_underflow` out 1: sticky; set by `PC_RET` on an empty RAS.

## Operation
- Nothing changes when `pc_en`=0. This covers the PC, EPC, RAS and flags; `align_err` drives 0 in that case.
- Priority when `pc_en`=1:
  - `exc`: `pc`←EXC_VEC, `epc`←`pc`. `push` and `pc_sel` are ignored.
  - `eret`: `pc`←`epc`. `push` is ignored.
  - Otherwise `pc` takes the selected target:
    - `PC_SEQ`: `pc_plus`
    - `PC_BR`: `br_target`
    - `PC_J`: `j_target`
    - `PC_JR`: `jr_target`
    - `PC_RET`: RAS top (pop), or `jr_target` with `ras_underflow`←1 if the RAS is empty.
  - Undefined `pc_sel` codes behave as `PC_SEQ`.
- Misalignment: if the selected target has a nonzero value in `[1:0]` (`exc`/`eret` not asserted), the unit traps:
  - `pc`←EXC_VEC, `epc`←`pc`
  - `align_err` pulses 1 for that cycle
  - no RAS push or pop occurs
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH):
  - Push when not full: write at top+1, count+1.
  - Push when full: overwrite the oldest entry (pointer wraps), count stays RAS_DEPTH.
  - Pop: read top, pointer−1 (wraps), count−1.
  - Push and `PC_RET` in the same cycle: pop first, then push. The top entry is replaced by `pc_plus` and count is unchanged. If the RAS was empty, the fallback and underflow rules apply, then one entry is pushed.
- Arithmetic is modulo 2^WIDTH. `pc_plus` wraps silently.
- `ras_underflow` clears only on reset.

## Timing
- All state updates on the rising edge of `clk` where `pc_en`=1. `pc`/`epc` reflect the new value one cycle later.
- `pc_plus`, `ras_empty` and `ras_full` are combinational from the registered state.
- `align_err` is combinational and valid in the same cycle as the trapping `pc_en`.
- Reset values: `pc`=RESET_VEC, `epc`=0, RAS count 0, pointer 0, `ras_underflow`=0. Hence `ras_empty`=1, `ras_full`=0, `align_err`=0.
- Reset asserted mid-operation overrides any pending update immediately (asynchronous). RAS contents need not be cleared.

## Structure
- Shared package `pc_pkg` holds the `pc_sel` encodings (`PC_SEQ`=0, `PC_BR`=1, `PC_J`=2, `PC_JR`=3, `PC_RET`=4) and the default RESET_VEC/EXC_VEC constants. The control FSM imports the same package.
- Sub-module `pc_ras` contains the circular stack and exposes `push`, `pop`, `din`, `top`, `empty`, `full`. `pc_unit` holds the next-PC mux, EPC, trap logic and flags.

## Test plan
- Reset, then 3 cycles of `PC_SEQ` with `pc_en`=1 → `pc`=0x0, then 0x4, 0x8, 0xC. Repeating with `pc_en`=0 leaves `pc` at 0xC.
- At `pc`=0x10: `PC_J` to 0x100 with `push`=1, then `PC_RET` → `pc`=0x100, then 0x14. `ras_empty` returns to 1.
- 5 nested pushes with `RAS_DEPTH`=4, then 5 `PC_RET` (`jr_target`=0x200):
  - the first 4 returns give the 4 newest return addresses, newest first
  - the 5th return gives `pc`=0x200 and sets `ras_underflow`=1
- At `pc`=0x40: `exc`=1 together with `pc_sel`=`PC_BR` → `pc`=0x180, `epc`=0x40. A following `eret` → `pc`=0x40.
- `PC_JR` with `jr_target`=0x102 at `pc`=0x20 → `align_err`=1 for one cycle, `pc`=0x180, `epc`=0x20, RAS unchanged.
- Assert `reset` asynchronously between edges during a `PC_BR` → `pc`=RESET_VEC immediately, `ras_empty`=1, `ras_underflow`=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit and the control FSM.
//   - pc_sel_e      : next-PC source encodings driven on pc_sel
//   - DEF_RESET_VEC : default PC after reset
//   - DEF_EXC_VEC   : default exception / trap vector
//   - is_misaligned : word-alignment check on the low address bits
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3,
    PC_RET = 3'd4
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

  // Instruction addresses must be word aligned; any set bit in [1:0] traps.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset : clock, asynchronous active-high reset (pointer and count only)
//   push       : write din as the new top entry
//   pop        : discard the top entry (ignored when empty)
//   din        : return address to push
//   top        : current top entry
//   empty/full : occupancy flags
// Push on a full stack overwrites the oldest entry. Push together with a
// pop replaces the top entry in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    ptr_r;
  logic [CW-1:0]    count_r;

  logic          pop_s;
  logic          swap_s;
  logic          push_only_s;
  logic          pop_only_s;
  logic [PW-1:0] ptr_inc_s;
  logic [PW-1:0] ptr_dec_s;

  // Decode the requested operation; a pop on an empty stack is a no-op.
  always_comb begin
    pop_s       = pop & ~empty;
    swap_s      = pop_s & push;
    push_only_s = push & ~pop_s;
    pop_only_s  = pop_s & ~push;
    // DEPTH is a power of two, so the pointer wraps naturally.
    ptr_inc_s   = ptr_r + PW'(1'b1);
    ptr_dec_s   = ptr_r - PW'(1'b1);
  end

  // Top pointer and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (push_only_s) begin
      ptr_r <= ptr_inc_s;
      if (!full) begin
        count_r <= count_r + CW'(1'b1);
      end
    end else if (pop_only_s) begin
      ptr_r   <= ptr_dec_s;
      count_r <= count_r - CW'(1'b1);
    end
  end

  // Entry storage; contents are not reset, only the pointer/count are.
  always_ff @(posedge clk) begin
    if (swap_s) begin
      mem_r[ptr_r] <= din;
    end else if (push_only_s) begin
      mem_r[ptr_inc_s] <= din;
    end
  end

  assign top   = mem_r[ptr_r];
  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == DEPTH_C);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection, exception/ERET handling,
// misalignment trapping and a return-address stack.
//   clk, reset     : clock, asynchronous active-high reset
//   pc_en          : PC write enable; nothing changes while low
//   pc_sel         : next-PC source (pc_sel_e)
//   br_target      : branch target
//   j_target       : jump target
//   jr_target      : register target; fallback for PC_RET on an empty stack
//   push           : push pc_plus onto the return stack
//   exc / eret     : take exception / return from exception
//   pc, epc        : registered PC and saved exception PC
//   pc_plus        : pc + INC
//   align_err      : trap indication for the current enabled cycle
//   ras_empty/full : return stack occupancy
//   ras_underflow  : sticky, a return was attempted on an empty stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [WIDTH-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic [2:0]       pc_sel,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] j_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             push,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             align_err,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] epc_r;
  logic             underflow_r;

  logic [WIDTH-1:0] ras_top_s;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] pc_next_s;
  logic             ret_sel_s;
  logic             normal_s;
  logic             trap_s;
  logic             flow_s;
  logic             ras_push_s;
  logic             ras_pop_s;
  logic             uf_set_s;

  assign pc_plus = pc_r + INC_W;

  // Next-PC selection, trap detection and return-stack control.
  always_comb begin
    ret_sel_s = 1'b0;
    case (pc_sel)
      PC_SEQ: target_s = pc_plus;
      PC_BR:  target_s = br_target;
      PC_J:   target_s = j_target;
      PC_JR:  target_s = jr_target;
      PC_RET: begin
        ret_sel_s = 1'b1;
        if (ras_empty) begin
          target_s = jr_target;
        end else begin
          target_s = ras_top_s;
        end
      end
      default: target_s = pc_plus;
    endcase

    // exc/eret override the selected target, so only an ordinary flow
    // change can trap; a trapped cycle leaves the stack untouched.
    normal_s   = pc_en & ~exc & ~eret;
    trap_s     = normal_s & is_misaligned(target_s[1:0]);
    flow_s     = normal_s & ~trap_s;
    ras_push_s = flow_s & push;
    ras_pop_s  = flow_s & ret_sel_s;
    uf_set_s   = ras_pop_s & ras_empty;

    if (exc | trap_s) begin
      pc_next_s = EXC_VEC;
    end else if (eret) begin
      pc_next_s = epc_r;
    end else begin
      pc_next_s = target_s;
    end
  end

  // PC, EPC and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r        <= RESET_VEC;
      epc_r       <= {WIDTH{1'b0}};
      underflow_r <= 1'b0;
    end else if (pc_en) begin
      pc_r <= pc_next_s;
      if (exc | trap_s) begin
        epc_r <= pc_r;
      end
      if (uf_set_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push_s),
    .pop   (ras_pop_s),
    .din   (pc_plus),
    .top   (ras_top_s),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc            = pc_r;
  assign epc           = epc_r;
  assign align_err     = trap_s;
  assign ras_underflow = underflow_r;

endmodule
